// File: rtl/mips_trace_buffer.sv
// Change-capture trace buffer: records {ch_data, ts} whenever a monitored channel changes; optional trigger gating under `TRACE_TRIGGER_EN`.
// Latency: an entry recorded at edge N is on rd_data/rd_ts with rd_valid=1 after edge N; pops take effect at the edge.
// Backpressure: none on capture; a record while full (and not popping) is dropped and sets the sticky overflow flag.
module mips_trace_buffer #(
    parameter int WIDTH    = 32,
    parameter int NUM_CH   = 3,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*WIDTH-1:0]     ch_data,
    input  logic                        capture_en,
    input  logic                        rd_en,
`ifdef TRACE_TRIGGER_EN
    input  logic [NUM_CH*WIDTH-1:0]     trig_mask,
    input  logic [NUM_CH*WIDTH-1:0]     trig_value,
    output logic                        triggered,
`endif
    output logic                        rd_valid,
    output logic [NUM_CH*WIDTH-1:0]     rd_data,
    output logic [TS_WIDTH-1:0]         rd_ts,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [NUM_CH*WIDTH-1:0] dat;
        logic [TS_WIDTH-1:0]     ts;
    } entry_t;

    entry_t                    mem_q [DEPTH];
    entry_t                    head_q, head_d;
    entry_t                    new_entry;
    logic [TS_WIDTH-1:0]       ts_q, ts_d;
    logic [NUM_CH*WIDTH-1:0]   prev_q, prev_d;
    logic                      first_flag_q, first_flag_d;
    logic                      cap_en_q, cap_en_d;
    logic                      overflow_q, overflow_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;

    logic                      first_eff;
    logic                      changed;
    logic                      trig_ok;
    logic                      record;
    logic                      empty;
    logic                      full_int;
    logic                      pop;
    logic                      push;

`ifdef TRACE_TRIGGER_EN
    logic                      triggered_q, triggered_d;
    logic                      trig_match;
`endif

    always_comb begin
        ts_d      = ts_q + 1'b1;
        cap_en_d  = capture_en;
        changed   = (ch_data != prev_q);
        // A rising capture_en opens a new window and forces its first sample.
        first_eff = first_flag_q || (capture_en && !cap_en_q);

`ifdef TRACE_TRIGGER_EN
        trig_match  = ((ch_data & trig_mask) == (trig_value & trig_mask));
        trig_ok     = triggered_q || trig_match;
        triggered_d = trig_ok;
`else
        trig_ok     = 1'b1;
`endif

        record       = capture_en && trig_ok && (first_eff || changed);
        prev_d       = capture_en ? ch_data : prev_q;
        first_flag_d = record ? 1'b0 : first_eff;

        empty    = (count_q == '0);
        full_int = (count_q == DEPTH_C);
        pop      = rd_en && !empty;
        // A pop on the same edge frees the slot, so a full buffer still accepts.
        push     = record && (!full_int || pop);

        overflow_d = overflow_q || (record && full_int && !pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        new_entry.dat = ch_data;
        new_entry.ts  = ts_d;

        // Head register keeps the last head visible once the buffer drains.
        head_d = head_q;
        if (push && (empty || (pop && count_q == CW'(1)))) begin
            head_d = new_entry;
        end else if (pop && count_q > CW'(1)) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q         <= '0;
            prev_q       <= '0;
            first_flag_q <= 1'b1;
            cap_en_q     <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
        end else begin
            ts_q         <= ts_d;
            prev_q       <= prev_d;
            first_flag_q <= first_flag_d;
            cap_en_q     <= cap_en_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
        end
    end

`ifdef TRACE_TRIGGER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            triggered_q <= 1'b0;
        end else begin
            triggered_q <= triggered_d;
        end
    end

    assign triggered = triggered_q;
`endif

    // Storage needs no reset: every slot is written before it can reach the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = head_q.dat;
    assign rd_ts    = head_q.ts;
    assign count    = count_q;
    assign full     = full_int;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer with a scoreboard of expected entries.
module tb_mips_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [95:0] dat;
        logic [15:0] ts;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [95:0] ch_data;
    logic        capture_en;
    logic        rd_en;
    logic        rd_valid;
    logic [95:0] rd_data;
    logic [15:0] rd_ts;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
`ifdef TRACE_TRIGGER_EN
    logic [95:0] trig_mask;
    logic [95:0] trig_value;
    logic        triggered;
`endif

    mips_trace_buffer #(
        .WIDTH(32), .NUM_CH(3), .DEPTH(DEPTH), .TS_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_data    (ch_data),
        .capture_en (capture_en),
        .rd_en      (rd_en),
`ifdef TRACE_TRIGGER_EN
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .triggered  (triggered),
`endif
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ts      (rd_ts),
        .count      (count),
        .full       (full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    ent_t        sb[$];
    logic [15:0] m_ts;
    logic [95:0] m_prev;
    logic        m_first;
    logic        m_cap;
    logic        m_ovf;
    logic        m_trig;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        capture_en = 1'b0;
        rd_en      = 1'b0;
        ch_data    = '0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        sb.delete();
        m_ts    = '0;
        m_prev  = '0;
        m_first = 1'b1;
        m_cap   = 1'b0;
        m_ovf   = 1'b0;
        m_trig  = 1'b0;
    endtask

    // One clock: drive at negedge, score pops against the current head, check flags after the edge.
    task automatic step(input logic [95:0] d, input logic cap, input logic rden);
        logic rec, pop, push, match, first_eff;
        ent_t exp_e;
        @(negedge clk);
        ch_data    = d;
        capture_en = cap;
        rd_en      = rden;
        m_ts       = m_ts + 16'd1;
`ifdef TRACE_TRIGGER_EN
        match = ((d & trig_mask) == (trig_value & trig_mask));
`else
        match = 1'b1;
`endif
        first_eff = m_first || (cap && !m_cap);
        rec  = cap && (m_trig || match) && (first_eff || (d != m_prev));
        pop  = rden && (sb.size() != 0);
        push = rec && ((sb.size() < DEPTH) || pop);
        if (pop) begin
            chk("pop_valid", 128'(rd_valid), 128'(1'b1));
            exp_e = sb.pop_front();
            chk("pop_data", 128'(rd_data), 128'(exp_e.dat));
            chk("pop_ts", 128'(rd_ts), 128'(exp_e.ts));
        end
        if (push) begin
            exp_e.dat = d;
            exp_e.ts  = m_ts;
            sb.push_back(exp_e);
        end else if (rec) begin
            m_ovf = 1'b1;
        end
        m_first = rec ? 1'b0 : first_eff;
        if (cap) m_prev = d;
        m_cap  = cap;
        m_trig = m_trig || match;
        @(posedge clk);
        #1;
        chk("count", 128'(count), 128'(sb.size()));
        chk("rd_valid", 128'(rd_valid), 128'(sb.size() != 0));
        chk("full", 128'(full), 128'(sb.size() == DEPTH));
        chk("overflow", 128'(overflow), 128'(m_ovf));
`ifdef TRACE_TRIGGER_EN
        chk("triggered", 128'(triggered), 128'(m_trig));
`endif
    endtask

    task automatic drain();
        int n;
        n = sb.size();
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [95:0] d;
        rst        = 1'b1;
        ch_data    = '0;
        capture_en = 1'b0;
        rd_en      = 1'b0;
`ifdef TRACE_TRIGGER_EN
        trig_mask  = '0;
        trig_value = '0;
`endif
        do_reset();
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_valid", 128'(rd_valid), 128'(0));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        chk("rst_data", 128'(rd_data), 128'(0));
        chk("rst_ts", 128'(rd_ts), 128'(0));

        // Constant data: one forced entry at ts=1.
        for (int k = 0; k < 10; k++) step('0, 1'b1, 1'b0);
        chk("t1_count", 128'(count), 128'(1));
        chk("t1_ts", 128'(rd_ts), 128'(1));

        // Changes at ts=5 (ch0) and ts=8 (ch2).
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            d = '0;
            if (k >= 5) d[31:0]  = 32'hDEADBEEF;
            if (k >= 8) d[95:64] = 32'h1;
            step(d, 1'b1, 1'b0);
        end
        chk("t2_count", 128'(count), 128'(3));
        chk("t2_ts0", 128'(rd_ts), 128'(1));
        step('0, 1'b0, 1'b1);
        chk("t2_ts1", 128'(rd_ts), 128'(5));
        chk("t2_ch0", 128'(rd_data[31:0]), 128'(32'hDEADBEEF));
        step('0, 1'b0, 1'b1);
        chk("t2_ts2", 128'(rd_ts), 128'(8));
        chk("t2_ch2", 128'(rd_data[95:64]), 128'(32'h1));
        step('0, 1'b0, 1'b1);
        chk("t2_empty", 128'(rd_valid), 128'(0));

        // Change every cycle for 20 cycles: overflow, first 16 intact.
        do_reset();
        for (int k = 1; k <= 20; k++) step({3{32'(k)}}, 1'b1, 1'b0);
        chk("t3_count", 128'(count), 128'(16));
        chk("t3_full", 128'(full), 128'(1));
        chk("t3_ovf", 128'(overflow), 128'(1));
        drain();

        // Full buffer with a same-edge pop is not an overflow.
        do_reset();
        for (int k = 1; k <= 16; k++) step({3{32'(k)}}, 1'b1, 1'b0);
        chk("t4_full", 128'(full), 128'(1));
        step({3{32'd17}}, 1'b1, 1'b1);
        chk("t4_count", 128'(count), 128'(16));
        chk("t4_ovf", 128'(overflow), 128'(0));
        drain();
        chk("t4_last_ts", 128'(rd_ts), 128'(17));

        // Reading while empty changes nothing; the last head stays visible.
        for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b1);
        chk("t5_count", 128'(count), 128'(0));
        chk("t5_hold_ts", 128'(rd_ts), 128'(17));
        chk("t5_hold_data", 128'(rd_data), 128'({3{32'd17}}));

        // Mid-stream reset after an overflow.
        for (int k = 1; k <= 20; k++) step({3{32'(k + 100)}}, 1'b1, 1'b0);
        chk("t5_ovf_set", 128'(overflow), 128'(1));
        do_reset();
        chk("t5_rst_count", 128'(count), 128'(0));
        chk("t5_rst_ovf", 128'(overflow), 128'(0));
        chk("t5_rst_valid", 128'(rd_valid), 128'(0));
        chk("t5_rst_data", 128'(rd_data), 128'(0));

        // New capture window forces an entry even with unchanged data; pops interleaved.
        step({3{32'hA}}, 1'b1, 1'b0);
        step({3{32'hA}}, 1'b1, 1'b0);
        step({3{32'hB}}, 1'b0, 1'b0);
        step({3{32'hB}}, 1'b0, 1'b0);
        step({3{32'hA}}, 1'b1, 1'b0);
        chk("win_count", 128'(count), 128'(2));
        for (int k = 0; k < 6; k++) step({3{32'(k + 200)}}, 1'b1, 1'b1);
        drain();

`ifdef TRACE_TRIGGER_EN
        // Trigger on ch1 == 0x10: nothing recorded before the match cycle.
        do_reset();
        trig_mask  = {32'h0, 32'hFFFFFFFF, 32'h0};
        trig_value = {32'h0, 32'h00000010, 32'h0};
        for (int k = 1; k <= 4; k++) step({32'h0, 32'(k), 32'(k + 50)}, 1'b1, 1'b0);
        chk("trg_none", 128'(count), 128'(0));
        chk("trg_pre", 128'(triggered), 128'(0));
        step({32'h0, 32'h10, 32'h55}, 1'b1, 1'b0);
        chk("trg_set", 128'(triggered), 128'(1));
        chk("trg_ts", 128'(rd_ts), 128'(5));
        for (int k = 1; k <= 3; k++) step({32'h0, 32'(k + 20), 32'h55}, 1'b1, 1'b0);
        chk("trg_count", 128'(count), 128'(4));
        drain();
        trig_mask = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
